// File: rtl/if_stage_pkg.sv
// if_stage_pkg
//   Shared definitions for the instruction fetch stage: default widths,
//   the 2-bit opcode encodings carried in the top of each instruction
//   word, and the fetch FSM state type.
package if_stage_pkg;

  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 16;

  localparam logic [1:0] OP_R    = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_LW   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// if_fifo
//   Two-entry FIFO of {instruction, pc} pairs between the fetch logic and
//   decode. A flush empties it and takes priority over a same-cycle
//   push or pop. Head outputs read as zero while the FIFO is empty.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  discard all entries
//   push, push_instr/pc    write one entry
//   pop                    remove the head entry
//   count, valid           occupancy (0..2), non-empty flag
//   head_instr, head_pc    oldest entry
module if_fifo
  import if_stage_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [PC_W-1:0]    push_pc,
  input  logic               pop,
  output logic [1:0]         count,
  output logic               valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [PC_W-1:0]    head_pc
);

  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [PC_W-1:0]    pc_q    [2];
  logic [PC_W-1:0]    pc_d    [2];
  logic               wr_q, wr_d;
  logic               rd_q, rd_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  // Guards keep the pointers consistent even if a caller pushes into a
  // full FIFO or pops an empty one.
  always_comb begin
    do_push = push && (count_q != 2'd2);
    do_pop  = pop && (count_q != 2'd0);
    instr_d = instr_q;
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_push) begin
        instr_d[wr_q] = push_instr;
        pc_d[wr_q]    = push_pc;
        wr_d          = ~wr_q;
      end
      if (do_pop) begin
        rd_d = ~rd_q;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 2'd1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign valid      = (count_q != 2'd0);
  assign head_instr = valid ? instr_q[rd_q] : '0;
  assign head_pc    = valid ? pc_q[rd_q] : '0;

endmodule

// File: rtl/if_stage.sv
// if_stage
//   Instruction fetch stage. Issues one memory read at a time, buffers
//   up to two fetched instructions for decode, and handles redirects by
//   flushing the buffer and discarding the in-flight response.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   imem_req/addr, imem_gnt            request handshake to instruction memory
//   imem_rvalid, imem_rdata            read response
//   redirect_valid, redirect_pc        branch/jump redirect
//   id_valid/ready, id_instr/pc/opcode instruction handed to decode
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              PC_W     = DEF_PC_W,
  parameter int              INSTR_W  = DEF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [1:0]         id_opcode
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            drop_q, drop_d;

  logic            fifo_push, fifo_pop, fifo_flush;
  logic [1:0]      fifo_count, count_after;

  // pc_q is the next address to fetch; addr_q is the address of the
  // request currently held or awaiting its response. Keeping them apart
  // lets a redirect retarget pc_q while a stalled request stays stable.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    fifo_flush = redirect_valid;
    fifo_pop   = id_valid && id_ready && !redirect_valid;
    fifo_push  = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect_valid;

    count_after = fifo_count;
    if (fifo_push) count_after = count_after + 2'd1;
    if (fifo_pop)  count_after = count_after - 2'd1;
    if (redirect_valid) count_after = 2'd0;

    case (state_q)
      S_IDLE: begin
        if ((fifo_count < 2'd2) || redirect_valid) state_d = S_REQ;
      end
      S_REQ: begin
        // A granted request that was already marked dropped must not
        // advance the redirect target held in pc_q.
        if (redirect_valid) drop_d = 1'b1;
        if (imem_gnt) begin
          state_d = S_WAIT;
          if (!drop_q) pc_d = pc_q + 1'b1;
        end
      end
      S_WAIT: begin
        // A redirect coinciding with the response simply discards it;
        // no drop flag is needed since nothing else is outstanding.
        if (imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = (count_after < 2'd2) ? S_REQ : S_IDLE;
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) pc_d = redirect_pc;
    if ((state_d == S_REQ) && (state_q != S_REQ)) addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  if_fifo #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (fifo_flush),
    .push       (fifo_push),
    .push_instr (imem_rdata),
    .push_pc    (addr_q),
    .pop        (fifo_pop),
    .count      (fifo_count),
    .valid      (id_valid),
    .head_instr (id_instr),
    .head_pc    (id_pc)
  );

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = addr_q;
  assign id_opcode = id_instr[INSTR_W-1 -: 2];

endmodule
